// File: rtl/reg_scoreboard.sv
// Register write scoreboard: per-register pending-write counters that raise
// o_stall on RAW hazards and on counter saturation at issue.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), async active-high reset
//   i_rs1, i_rs2        ID-stage source registers
//   i_check_regs        operand usage: 0 none, 1 rs1, 2 rs2, 3 both
//   i_issue_valid/_rd   instruction leaving ID with destination rd
//   i_wb_valid/_rd      writeback retiring destination rd
//   i_flush             discard every pending write
//   o_stall             hold ID/IF, bubble into EXE
//   o_busy_mask         registered: bit r set while counter r is nonzero
//   o_pending_full      issuing rd already has the maximum writers in flight
//   o_wb_err            sticky: writeback seen for a register with no writer
//   o_stall_cycles      saturating count of stalled cycles
module reg_scoreboard #(
   parameter int ALEN   = 5,
   parameter int NREGS  = 32,
   parameter int CNT_W  = 2,
   parameter int PERF_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [ALEN-1:0]   i_rs1,
   input  logic [ALEN-1:0]   i_rs2,
   input  logic [1:0]        i_check_regs,
   input  logic              i_issue_valid,
   input  logic [ALEN-1:0]   i_issue_rd,
   input  logic              i_wb_valid,
   input  logic [ALEN-1:0]   i_wb_rd,
   input  logic              i_flush,
   output logic              o_stall,
   output logic [NREGS-1:0]  o_busy_mask,
   output logic              o_pending_full,
   output logic              o_wb_err,
   output logic [PERF_W-1:0] o_stall_cycles
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [NREGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NREGS-1:0]            busy_q, busy_d;
   logic                        wb_err_q, wb_err_d;
   logic [PERF_W-1:0]           stall_cnt_q, stall_cnt_d;

   logic haz1, haz2, full, stall, issue_ok;
   logic wb_zero;
   logic iss, ret;

   // Hazards look only at registered counters, so a writeback in the
   // same cycle does not release the stall until the following cycle.
   assign haz1 = i_check_regs[0] && (i_rs1 != '0)
               && (cnt_q[i_rs1] != '0);
   assign haz2 = i_check_regs[1] && (i_rs2 != '0)
               && (cnt_q[i_rs2] != '0);

   assign full = i_issue_valid && (i_issue_rd != '0)
               && (cnt_q[i_issue_rd] == CNT_MAX);

   assign stall    = haz1 | haz2 | full;
   assign issue_ok = i_issue_valid && !stall && !i_flush;

   // Retire against an idle counter; a flush discards the retire entirely.
   assign wb_zero = i_wb_valid && (i_wb_rd != '0)
                  && (cnt_q[i_wb_rd] == '0) && !i_flush;

   always_comb begin
      cnt_d  = cnt_q;
      busy_d = '0;
      iss    = 1'b0;
      ret    = 1'b0;
      for (int r = 1; r < NREGS; r++) begin
         iss = issue_ok && (i_issue_rd == ALEN'(r));
         ret = i_wb_valid && (i_wb_rd == ALEN'(r));
         if (i_flush) begin
            cnt_d[r] = '0;
         end else if (iss && !ret) begin
            cnt_d[r] = cnt_q[r] + CNT_ONE;
         end else if (ret && !iss && (cnt_q[r] != '0)) begin
            cnt_d[r] = cnt_q[r] - CNT_ONE;
         end
      end
      // x0 is never a real destination.
      cnt_d[0] = '0;
      for (int r = 0; r < NREGS; r++) begin
         busy_d[r] = |cnt_d[r];
      end
   end

   assign wb_err_d = wb_err_q | wb_zero;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != {PERF_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + PERF_W'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q       <= '0;
         busy_q      <= '0;
         wb_err_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         wb_err_q    <= wb_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign o_stall        = stall;
   assign o_pending_full = full;
   assign o_busy_mask    = busy_q;
   assign o_wb_err       = wb_err_q;
   assign o_stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios followed by random traffic,
// all compared against an array-of-counts reference model.
module tb_reg_scoreboard;

   localparam int ALEN   = 5;
   localparam int NREGS  = 32;
   localparam int CNT_W  = 2;
   localparam int PERF_W = 4;
   localparam int CMAX   = 3;
   localparam int SMAX   = 15;

   logic              clk = 1'b0;
   logic              rst;
   logic [ALEN-1:0]   rs1, rs2, issue_rd, wb_rd;
   logic [1:0]        check;
   logic              issue_valid, wb_valid, flush;
   logic              o_stall, o_pending_full, o_wb_err;
   logic [NREGS-1:0]  o_busy_mask;
   logic [PERF_W-1:0] o_stall_cycles;

   int cnt[NREGS];
   bit err_m;
   int sc_m;
   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   reg_scoreboard #(
      .ALEN(ALEN), .NREGS(NREGS), .CNT_W(CNT_W), .PERF_W(PERF_W)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_rs1(rs1), .i_rs2(rs2), .i_check_regs(check),
      .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
      .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
      .i_flush(flush),
      .o_stall(o_stall), .o_busy_mask(o_busy_mask),
      .o_pending_full(o_pending_full), .o_wb_err(o_wb_err),
      .o_stall_cycles(o_stall_cycles)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_full();
      return issue_valid && issue_rd != 0 && cnt[issue_rd] == CMAX;
   endfunction

   function automatic bit m_stall();
      bit h1, h2;
      h1 = check[0] && rs1 != 0 && cnt[rs1] > 0;
      h2 = check[1] && rs2 != 0 && cnt[rs2] > 0;
      return h1 || h2 || m_full();
   endfunction

   function automatic logic [NREGS-1:0] m_busy();
      logic [NREGS-1:0] m;
      m = '0;
      for (int i = 0; i < NREGS; i++) m[i] = (cnt[i] > 0);
      return m;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) cnt[i] = 0;
      err_m = 0;
      sc_m  = 0;
   endtask

   task automatic drive(input logic [4:0] r1, input logic [4:0] r2,
                        input logic [1:0] cr, input logic iv,
                        input logic [4:0] ird, input logic wv,
                        input logic [4:0] wrd, input logic fl);
      rs1 = r1; rs2 = r2; check = cr;
      issue_valid = iv; issue_rd = ird;
      wb_valid = wv; wb_rd = wrd; flush = fl;
   endtask

   task automatic settle_check();
      #2;
      chk("stall", 64'(o_stall), 64'(m_stall()));
      chk("full", 64'(o_pending_full), 64'(m_full()));
      chk("busy", 64'(o_busy_mask), 64'(m_busy()));
      chk("wb_err", 64'(o_wb_err), 64'(err_m));
      chk("stall_cycles", 64'(o_stall_cycles), 64'(sc_m));
   endtask

   task automatic advance();
      int nx[NREGS];
      bit st, acc, inc, dec;
      st  = m_stall();
      acc = issue_valid && !st && !flush;
      nx  = cnt;
      if (flush) begin
         for (int i = 0; i < NREGS; i++) nx[i] = 0;
      end else begin
         inc = acc && issue_rd != 0;
         dec = wb_valid && wb_rd != 0;
         if (!(inc && dec && issue_rd == wb_rd)) begin
            if (inc) nx[issue_rd] = nx[issue_rd] + 1;
            if (dec && cnt[wb_rd] > 0) nx[wb_rd] = nx[wb_rd] - 1;
         end
         if (dec && cnt[wb_rd] == 0) err_m = 1;
      end
      if (st && sc_m < SMAX) sc_m++;
      @(posedge clk);
      #1;
      cnt = nx;
   endtask

   task automatic cyc();
      settle_check();
      advance();
   endtask

   initial begin
      int sc_before;
      logic [4:0] r;
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #3;
      chk("rst_busy", 64'(o_busy_mask), 64'(0));
      chk("rst_err", 64'(o_wb_err), 64'(0));
      chk("rst_sc", 64'(o_stall_cycles), 64'(0));
      chk("rst_stall", 64'(o_stall), 64'(0));
      chk("rst_full", 64'(o_pending_full), 64'(0));
      #9 rst = 1'b0;

      // RAW on x5, stall held through the writeback cycle
      drive(0, 0, 0, 1, 5, 0, 0, 0); cyc();
      drive(5, 0, 1, 0, 0, 0, 0, 0); settle_check();
      chk("raw_stall", 64'(o_stall), 64'(1));
      chk("raw_busy5", 64'(o_busy_mask[5]), 64'(1));
      advance();
      drive(5, 0, 1, 0, 0, 1, 5, 0); settle_check();
      chk("raw_wb_cycle", 64'(o_stall), 64'(1));
      advance();
      drive(5, 0, 1, 0, 0, 0, 0, 0); settle_check();
      chk("raw_release", 64'(o_stall), 64'(0));
      advance();

      // x0 never tracked
      drive(0, 0, 0, 1, 0, 0, 0, 0); cyc();
      drive(0, 0, 3, 0, 0, 0, 0, 0); settle_check();
      chk("x0_stall", 64'(o_stall), 64'(0));
      chk("x0_busy", 64'(o_busy_mask), 64'(0));
      advance();

      // counter saturation on x7
      repeat (3) begin drive(0, 0, 0, 1, 7, 0, 0, 0); cyc(); end
      drive(0, 0, 0, 1, 7, 0, 0, 0); settle_check();
      chk("full7", 64'(o_pending_full), 64'(1));
      chk("full7_stall", 64'(o_stall), 64'(1));
      advance();
      chk("cnt7_model", 64'(cnt[7]), 64'(3));
      drive(0, 0, 0, 1, 7, 1, 7, 0); settle_check();
      chk("full7_wb", 64'(o_pending_full), 64'(1));
      advance();
      drive(0, 0, 0, 1, 7, 0, 0, 0); settle_check();
      chk("full7_clear", 64'(o_pending_full), 64'(0));
      advance();
      repeat (3) begin drive(0, 0, 0, 0, 0, 1, 7, 0); cyc(); end

      // simultaneous issue and retire of x9
      drive(0, 0, 0, 1, 9, 0, 0, 0); cyc();
      drive(0, 0, 0, 1, 9, 1, 9, 0); cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0); settle_check();
      chk("same_busy9", 64'(o_busy_mask[9]), 64'(1));
      advance();
      drive(0, 0, 0, 0, 0, 1, 9, 0); cyc();

      // flush with concurrent issue
      drive(0, 0, 0, 1, 3, 0, 0, 0); cyc();
      drive(0, 0, 0, 1, 3, 0, 0, 0); cyc();
      drive(0, 0, 0, 1, 4, 0, 0, 0); cyc();
      sc_before = sc_m;
      drive(0, 0, 0, 1, 6, 0, 0, 1); cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0); settle_check();
      chk("flush_busy", 64'(o_busy_mask), 64'(0));
      chk("flush_sc", 64'(o_stall_cycles), 64'(sc_before));
      advance();

      // writeback without writer, then async reset mid-cycle
      drive(0, 0, 0, 0, 0, 1, 12, 0); cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0); settle_check();
      chk("wb_err_set", 64'(o_wb_err), 64'(1));
      advance();
      cyc();
      #2 rst = 1'b1;
      #1;
      chk("arst_err", 64'(o_wb_err), 64'(0));
      chk("arst_sc", 64'(o_stall_cycles), 64'(0));
      chk("arst_busy", 64'(o_busy_mask), 64'(0));
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;

      // random traffic over a narrow register window
      for (int n = 0; n < 400; n++) begin
         r = 5'($urandom_range(1, 7));
         if ($urandom_range(0, 7) != 0) begin
            for (int k = 1; k < 8; k++)
               if (cnt[k] > 0 && $urandom_range(0, 1) == 1) r = 5'(k);
         end
         drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
               ($urandom_range(0, 9) < 4), r,
               ($urandom_range(0, 31) == 0));
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Producer side of the register hazard interface: tracks in-flight destination-register writes so decode can stall on RAW hazards without comparing against every downstream stage.
- Sits beside the ID stage; issue port driven at ID→EXE handoff, retire port driven by WB.
- Per-register pending-write counters, set on issue, cleared on writeback, bulk-cleared on flush.
- Drives the stall signal consumed by the ID/IF pipeline registers.

Parameters:
ALEN, 5, register address width
NREGS, 32, number of architectural registers (2**ALEN)
CNT_W, 2, width of per-register pending-write counter (max 2**CNT_W-1 outstanding writers)
PERF_W, 32, width of stall-cycle performance counter

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_rs1  input  ALEN  source register 1 of instruction in ID
i_rs2  input  ALEN  source register 2 of instruction in ID
i_check_regs  input  2  operand usage: 0=NONE, 1=RS1, 2=RS2, 3=RS1_RS2
i_issue_valid  input  1  ID instruction requests issue to EXE
i_issue_rd  input  ALEN  destination of issuing instruction (0 = no write)
i_wb_valid  input  1  WB stage retires a register write this cycle
i_wb_rd  input  ALEN  destination being written back
i_flush  input  1  pipeline flush; discard all pending writes
o_stall  output  1  hold ID/IF, insert bubble into EXE
o_busy_mask  output  NREGS  bit r = 1 when counter r != 0 (registered)
o_pending_full  output  1  issue blocked because counter[i_issue_rd] at max
o_wb_err  output  1  sticky: writeback to register with zero counter
o_stall_cycles  output  PERF_W  saturating count of cycles with o_stall=1

Behaviour:
- Reset (async, i_rst=1): all counters 0, o_busy_mask=0, o_wb_err=0, o_stall_cycles=0. o_stall, o_pending_full combinational from state; both 0 after reset when i_issue_valid=0.
- Register 0 never tracked: counter[0] hardwired 0, issue/wb with rd=0 ignored, rs=0 never hazards.
- Hazard (comb): haz1 = check includes RS1 && i_rs1!=0 && cnt[i_rs1]!=0; haz2 same for RS2. NONE → no hazard.
- o_pending_full = i_issue_valid && i_issue_rd!=0 && cnt[i_issue_rd]==max.
- o_stall = haz1 | haz2 | o_pending_full. Stall depends only on registered counters; a same-cycle writeback does not release the stall; release one cycle after the counter reaches 0.
- Issue accepted = i_issue_valid && ~o_stall && ~i_flush. Accepted with rd!=0 → cnt[rd]+1 next edge.
- Retire: i_wb_valid && i_wb_rd!=0 → cnt[wb_rd]-1 if nonzero; if zero, counter stays 0 and o_wb_err sets (sticky until reset).
- Simultaneous issue and retire same register: counter unchanged. Different registers: both applied.
- i_flush=1: all counters → 0 next edge; overrides same-cycle issue and retire; o_wb_err and o_stall_cycles untouched; no wb_err raised for a retire in the flush cycle.
- o_stall_cycles increments each cycle o_stall=1, saturates at all-ones, cleared only by reset.
- o_busy_mask updated the same edge as counters (no extra latency).
- Reset mid-operation: counters cleared immediately regardless of clock.

Test Plan:
- Reset then issue rd=5, next cycle rs1=5 check=RS1 → o_stall=1, busy_mask[5]=1; wb rd=5 → stall still 1 that cycle, 0 next cycle.
- Issue rd=0, then rs1=0 check=RS1_RS2 → o_stall=0, busy_mask=0.
- Issue rd=7 three times (no wb), 4th issue rd=7 → o_pending_full=1, o_stall=1, cnt[7] stays 3; one wb rd=7 → full clears next cycle.
- Same cycle issue rd=9 and wb rd=9 with cnt[9]=1 → cnt[9]=1 after edge, busy_mask[9]=1.
- cnt[3]=2, cnt[4]=1, flush with concurrent issue rd=6 → all counters 0, busy_mask=0, o_stall_cycles unchanged.
- wb rd=12 with cnt[12]=0 → o_wb_err=1 and stays 1; async reset pulse mid-cycle → o_wb_err=0, o_stall_cycles=0 before next edge.
